// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU/DIV/DIVU run as 32 shift-add or restoring shift-subtract steps.
// MTHI/MTLO writes are accepted only while idle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish through a single-cycle
// combinational multiplier. Divide timing does not change.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_pa;      // product high / partial remainder
    logic [WIDTH-1:0] r_pb;      // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] r_opnd;    // multiplicand or divisor magnitude
    logic             r_is_div;
    logic             r_neg_lo;  // product or quotient must be negated
    logic             r_neg_hi;  // remainder must be negated
    logic             r_raw;     // result already final (divide by zero)
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Operand decode and magnitudes for the signed ops
    logic             w_signed;
    logic             w_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div_zero;

    assign w_signed   = ~i_op[0];
    assign w_div      = i_op[1];
    assign w_a_neg    = w_signed & i_a[WIDTH-1];
    assign w_b_neg    = w_signed & i_b[WIDTH-1];
    assign w_mag_a    = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
    assign w_mag_b    = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;
    assign w_div_zero = w_div & (i_b == '0);

    // One multiply step: conditional add of the multiplicand into the high half
    logic [WIDTH:0] w_add;
    assign w_add = {1'b0, r_pa} + (r_pb[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // One restoring divide step: shift in the next dividend bit and trial-subtract
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    assign w_shift = {r_pa, r_pb[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

    // Sign fix applied when the result is written to HI/LO
    logic [PW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    assign w_prod_fix = r_neg_lo ? (~{r_pa, r_pb} + PW'(1)) : {r_pa, r_pb};
    assign w_q_fix    = r_neg_lo ? (~r_pb + WIDTH'(1)) : r_pb;
    assign w_r_fix    = r_neg_hi ? (~r_pa + WIDTH'(1)) : r_pa;

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle magnitude product; the sign fix is shared with the iterative path
    logic [PW-1:0] w_fast;
    assign w_fast = PW'(w_mag_a) * PW'(w_mag_b);
`endif

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pa     <= '0;
            r_pb     <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_raw    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_is_div <= w_div;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_div & w_a_neg;
                        r_raw    <= 1'b0;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                        r_opnd   <= w_mag_b;
                        if (w_div_zero) begin
                            r_pa    <= i_a;
                            r_pb    <= '1;
                            r_raw   <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (w_div) begin
                            r_pa    <= '0;
                            r_pb    <= w_mag_a;
                            r_state <= S_RUN;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            {r_pa, r_pb} <= w_fast;
                            r_state      <= S_FINISH;
`else
                            r_pa    <= '0;
                            r_pb    <= w_mag_a;
                            r_state <= S_RUN;
`endif
                        end
                    end else begin
                        if (i_hi_we) r_hi <= i_wdata;
                        if (i_lo_we) r_lo <= i_wdata;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_pa <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_pb <= {r_pb[WIDTH-2:0], w_ge};
                    end else begin
                        r_pa <= w_add[WIDTH:1];
                        r_pb <= {w_add[0], r_pb[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    if (r_raw) begin
                        r_hi <= r_pa;
                        r_lo <= r_pb;
                    end else if (r_is_div) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int DZ_LAT  = 2;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t mul_v [5];
    vec_t div_v [6];
    vec_t dz_v  [3];

    muldiv_unit #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_hi_we (hi_we),
        .i_lo_we (lo_we),
        .i_wdata (wdata),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clk = ~clk;

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one edge, then scramble operands.
    task automatic drive_start(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count cycles from the current one until done; busy_ok drops if busy fell early.
    task automatic wait_done(input int max, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= max; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mthi_mtlo();
        hi_we = 1'b1; wdata = 32'h1111_0000;
        step();
        hi_we = 1'b0;
        total++; if (hi !== 32'h1111_0000) begin bad++; $display("FAIL mthi got=%h want=11110000", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL mthi_lo_kept got=%h want=0", lo); end
        lo_we = 1'b1; wdata = 32'h0000_2222;
        step();
        lo_we = 1'b0;
        total++; if (lo !== 32'h0000_2222) begin bad++; $display("FAIL mtlo got=%h want=00002222", lo); end
        total++; if (hi !== 32'h1111_0000) begin bad++; $display("FAIL mtlo_hi_kept got=%h want=11110000", hi); end
    endtask

    task automatic test_multiply();
        int lat; bit bok;
        for (int i = 0; i < 5; i++) begin
            drive_start(mul_v[i].op, mul_v[i].a, mul_v[i].b);
            wait_done(60, lat, bok);
            total++; if (lat != MUL_LAT) begin bad++; $display("FAIL mul%0d_latency got=%0d want=%0d", i, lat, MUL_LAT); end
            total++; if (!bok) begin bad++; $display("FAIL mul%0d_busy_early_drop got=0 want=1", i); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul%0d_busy_at_done got=%0b want=0", i, busy); end
            total++; if (hi !== mul_v[i].hi) begin bad++; $display("FAIL mul%0d_hi got=%h want=%h", i, hi, mul_v[i].hi); end
            total++; if (lo !== mul_v[i].lo) begin bad++; $display("FAIL mul%0d_lo got=%h want=%h", i, lo, mul_v[i].lo); end
            step();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL mul%0d_done_width got=%0b want=0", i, done); end
        end
    endtask

    task automatic test_divide();
        int lat; bit bok;
        for (int i = 0; i < 6; i++) begin
            drive_start(div_v[i].op, div_v[i].a, div_v[i].b);
            wait_done(60, lat, bok);
            total++; if (lat != DIV_LAT) begin bad++; $display("FAIL div%0d_latency got=%0d want=%0d", i, lat, DIV_LAT); end
            total++; if (!bok) begin bad++; $display("FAIL div%0d_busy_early_drop got=0 want=1", i); end
            total++; if (hi !== div_v[i].hi) begin bad++; $display("FAIL div%0d_hi got=%h want=%h", i, hi, div_v[i].hi); end
            total++; if (lo !== div_v[i].lo) begin bad++; $display("FAIL div%0d_lo got=%h want=%h", i, lo, div_v[i].lo); end
            step();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL div%0d_done_width got=%0b want=0", i, done); end
        end
    endtask

    task automatic test_div_by_zero();
        int lat; bit bok;
        for (int i = 0; i < 3; i++) begin
            drive_start(dz_v[i].op, dz_v[i].a, dz_v[i].b);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL dz%0d_busy_t1 got=%0b want=1", i, busy); end
            wait_done(60, lat, bok);
            total++; if (lat != DZ_LAT) begin bad++; $display("FAIL dz%0d_latency got=%0d want=%0d", i, lat, DZ_LAT); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz%0d_busy_at_done got=%0b want=0", i, busy); end
            total++; if (hi !== dz_v[i].hi) begin bad++; $display("FAIL dz%0d_hi got=%h want=%h", i, hi, dz_v[i].hi); end
            total++; if (lo !== dz_v[i].lo) begin bad++; $display("FAIL dz%0d_lo got=%h want=%h", i, lo, dz_v[i].lo); end
            step();
        end
    endtask

    // Second start issued in the done cycle of the first.
    task automatic test_back_to_back();
        int lat; bit bok;
        drive_start(OP_DIVU, 32'd100, 32'd7);
        wait_done(60, lat, bok);
        total++; if (hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL b2b_first got=%h_%h want=00000002_0000000e", hi, lo); end
        drive_start(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(60, lat, bok);
        total++; if (lat != DIV_LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, DIV_LAT); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL b2b_second got=%h_%h want=ffffffff_fffffffd", hi, lo); end
        step();
    endtask

    task automatic test_busy_ignore();
        int lat; bit bok; int extra;
        drive_start(OP_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 4; i++) step();
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
        hi_we = 1'b1; wdata = 32'h0000_AAAA;
        step();
        start = 1'b0; hi_we = 1'b0;
        wait_done(60, lat, bok);
        total++; if (lat != DIV_LAT - 5) begin bad++; $display("FAIL busy_ign_latency got=%0d want=%0d", lat, DIV_LAT - 5); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL busy_ign_hi got=%h want=00000002", hi); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL busy_ign_lo got=%h want=0000000e", lo); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL busy_ign_second_done got=%0d want=0", extra); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL busy_ign_hi_late got=%h want=00000002", hi); end
        lo_we = 1'b1; wdata = 32'h55;
        step();
        lo_we = 1'b0;
        total++; if (lo !== 32'h55) begin bad++; $display("FAIL mtlo_idle got=%h want=00000055", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL mtlo_idle_hi got=%h want=00000002", hi); end
    endtask

    // MTHI/MTLO asserted with start: the operation wins.
    task automatic test_start_vs_write();
        int lat; bit bok;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
        drive_start(OP_MULTU, 32'd2, 32'd3);
        hi_we = 1'b0; lo_we = 1'b0;
        total++; if (hi !== 32'd2 || lo !== 32'h55) begin bad++; $display("FAIL start_vs_write_hold got=%h_%h want=00000002_00000055", hi, lo); end
        wait_done(60, lat, bok);
        total++; if (lat != MUL_LAT) begin bad++; $display("FAIL start_vs_write_latency got=%0d want=%0d", lat, MUL_LAT); end
        total++; if (hi !== 32'd0 || lo !== 32'd6) begin bad++; $display("FAIL start_vs_write_result got=%h_%h want=00000000_00000006", hi, lo); end
        step();
    endtask

    task automatic test_mid_reset();
        int extra;
        drive_start(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        for (int i = 0; i < 9; i++) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%0b want=1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL midrst_hilo got=%h_%h want=00000000_00000000", hi, lo); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) extra++;
            step();
        end
        total++; if (extra != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", extra); end
    endtask

    initial begin
        mul_v[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        mul_v[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        mul_v[2] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        mul_v[3] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        mul_v[4] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        div_v[0] = '{OP_DIVU, 32'd100,        32'd7,         32'd2,         32'd14};
        div_v[1] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        div_v[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        div_v[3] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        div_v[4] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        div_v[5] = '{OP_DIVU, 32'd5,         32'd9,         32'd5,         32'd0};

        dz_v[0]  = '{OP_DIV,  32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF};
        dz_v[1]  = '{OP_DIVU, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
        dz_v[2]  = '{OP_DIV,  32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        test_reset();
        test_mthi_mtlo();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_back_to_back();
        test_busy_ignore();
        test_start_vs_write();
        test_mid_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same two register operands the ALU receives. It computes MULT, MULTU, DIV and DIVU into the architectural HI/LO pair, and services MTHI/MTLO writes. The HI/LO outputs feed the MFHI/MFLO result path. A start/busy/done handshake lets control stall the pipeline while an operation runs.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin the operation selected by `op`; sampled only when `busy`=0.
- `op`  in  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `hi_we`, `lo_we`  in  1 each  MTHI / MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO hold a new result.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, `start`=1: latch operands and op.
  - Signed ops use operand magnitudes, with the result signs recorded at this point.
  - Load the 6-bit iteration counter with 32, then go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter decrements; at 0 go to FINISH.
- FINISH:
  - Apply the sign fix.
  - Write HI/LO: product high/low for multiply; remainder/quotient for divide.
  - Pulse `done` and return to IDLE.
- Multiply: full 64-bit product. MULT treats operands as two's complement; MULTU as unsigned.
- Divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (`b`=0 at start): skip RUN and go straight to FINISH. Result is HI=`a`, LO=0xFFFFFFFF, for both DIV and DIVU.
- `start` while `busy`=1: ignored; the running operation is unaffected.
- MTHI/MTLO:
  - With `busy`=0 and `start`=0, `hi_we`/`lo_we` write `wdata` at the edge.
  - Ignored while `busy`=1.
  - If asserted in the same cycle as `start`, `start` wins and the write is dropped.
- HI/LO change only on FINISH, on an accepted MTHI/MTLO, or on reset.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-operation aborts it: no `done`, HI/LO cleared.
- `start` accepted at edge T:
  - `busy`=1 in cycles T+1..T+33.
  - HI/LO are updated and `done`=1 in cycle T+34, with `busy`=0 in that same cycle.
  - Latency is 34 cycles, start edge to result.
- Divide by zero: `busy`=1 in cycle T+1 only; `done` and the result appear in T+2.
- `done` is high for exactly one cycle. A new `start` may be accepted in the `done` cycle.
- Operands are not required to be held after the start edge.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU complete through a single-cycle combinational multiplier. `busy`=1 for cycle T+1 only; result and `done` appear in T+2.
  - Divide timing is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: multiply uses the 32-step iterative path, with 34-cycle latency.

## Test plan
- MULT `a`=0xFFFFFFFD (-3), `b`=5 -> `done` at T+34, HI=0xFFFFFFFF, LO=0xFFFFFFF1. With the macro defined: same values at T+2.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIV 0x1234/0 -> `done` at T+2, HI=0x00001234, LO=0xFFFFFFFF.
- While busy, pulse `start` with new operands and assert `hi_we`=1, `wdata`=0xAAAA -> first result unchanged, no second `done`, HI not 0xAAAA. Once idle: `lo_we`, `wdata`=0x55 -> LO=0x55 next cycle.
- Assert `rst` at T+10 of a DIVU -> `busy`=0, HI=LO=0, no `done` pulse.
